vending_machine_multi: RTL and testbench
========================================

Name: vending_machine_multi

Overview:
- Parametrised successor to the single-product vending FSM.
- Supports NUM_ITEMS products with a per-item price table, accumulated credit, per-item stock counters, cancel/refund, and change return over a valid/ready handshake.
- Sits between the coin acceptor/keypad front end and the dispenser/change-hopper drivers.

Parameters:
- NUM_ITEMS, 8, number of selectable products (>=2).
- CREDIT_W, 8, width of coin value, price and credit; MAX_CREDIT = 2^CREDIT_W-1.
- STOCK_W, 4, width of each stock counter; MAX_STOCK = 2^STOCK_W-1.
- INIT_STOCK, 5, stock loaded into every item at reset (<= MAX_STOCK).
- IDX_W, $clog2(NUM_ITEMS), width of item index.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- coin_valid  in  1  coin inserted this cycle.
- coin_value  in  CREDIT_W  value of inserted coin.
- sel_valid  in  1  selection strobe.
- sel_idx  in  IDX_W  selected item.
- cancel  in  1  refund request.
- price_table  in  NUM_ITEMS*CREDIT_W  flat price bus; item i at [i*CREDIT_W +: CREDIT_W]; static during operation.
- restock_valid  in  1  restock strobe.
- restock_idx  in  IDX_W  item to restock.
- restock_count  in  STOCK_W  units to add.
- change_ready  in  1  hopper accepts change.
- dispense  out  1  one-cycle dispense pulse.
- dispense_idx  out  IDX_W  item being dispensed; valid with dispense.
- change_valid  out  1  change amount offered.
- change_amount  out  CREDIT_W  change value; stable while change_valid.
- credit  out  CREDIT_W  current credit.
- coin_reject  out  1  one-cycle pulse, coin not accepted.
- sel_error  out  1  one-cycle pulse: invalid index, sold out or insufficient credit.
- busy  out  1  high in DISPENSE and CHANGE.

Behaviour:
- Reset (async):
  - state=IDLE; credit=0; every stock=INIT_STOCK.
  - All outputs 0: dispense, dispense_idx, change_valid, change_amount, coin_reject, sel_error, busy.
  - Reset mid-operation discards credit without change and aborts any pending handshake.
- All outputs are registered and change one cycle after the causing input edge.
- States:
  - IDLE: accepted coin -> credit+=coin_value, go COLLECT. sel_valid -> sel_error. cancel ignored.
  - COLLECT, priority cancel > sel_valid > coin_valid:
    - cancel -> CHANGE.
    - sel_valid with sel_idx>=NUM_ITEMS, stock==0, or credit<price -> sel_error pulse; stay in COLLECT; credit unchanged.
    - otherwise valid sel -> DISPENSE; latch index.
    - coin present in a cycle where cancel or sel_valid wins -> coin_reject; credit unchanged.
  - DISPENSE (exactly 1 cycle):
    - dispense=1, dispense_idx=latched index.
    - stock[idx] decrements; credit -= price[idx].
    - Next state: CHANGE if remaining credit>0, else IDLE.
  - CHANGE:
    - change_valid=1; change_amount=credit, frozen on entry.
    - Hold until change_valid&&change_ready; on that edge credit=0, change_valid=0, go IDLE.
    - change_ready while change_valid=0 has no effect.
- Coins:
  - Rejected (coin_reject pulse, no credit change) in DISPENSE or CHANGE.
  - Rejected if credit+coin_value > MAX_CREDIT; sum computed at CREDIT_W+1 bits, no wrap.
  - coin_value==0 is accepted as a no-op; no state change from IDLE.
- Restock:
  - Honoured only in IDLE or COLLECT; ignored in DISPENSE/CHANGE and for restock_idx>=NUM_ITEMS.
  - stock = min(stock+restock_count, MAX_STOCK), saturating.
  - Restock and a valid selection of the same item in the same cycle: the selection sees pre-restock stock.
- Price 0 items are legal: dispense with no credit change. A selection in IDLE still errors because credit is required to leave IDLE.

Test Plan:
- Reset, price[2]=30, coin 20 then coin 20, sel_idx=2 -> credit 20, 40; dispense=1 with idx 2 one cycle after sel; stock[2] 5->4; change_valid with amount 10; change_ready=1 -> credit 0, IDLE.
- Exact payment: price[0]=25, coins 25, sel 0 -> dispense pulse, no change_valid, IDLE; repeat 5x then sel 0 -> sel_error, credit held.
- Insufficient credit and invalid index: credit 10, sel price 50 -> sel_error; NUM_ITEMS=6, sel_idx=7 -> sel_error; cancel -> change_amount 10.
- Credit saturation: CREDIT_W=8, credit 250, coin 10 -> coin_reject, credit 250; coin during CHANGE with change_ready=0 for 4 cycles -> coin_reject, change_amount stable.
- Simultaneous: cancel+sel+coin same cycle -> CHANGE, coin_reject, no dispense; restock item 1 by 15 at stock 4 -> saturates at 15.
- Async reset asserted during CHANGE -> change_valid drops immediately, credit 0, stocks back to INIT_STOCK.

Source files
------------

// File: rtl/vending_machine_multi.sv
// vending_machine_multi: multi-product vending FSM with price table, credit, stock, refund and change handshake
module vending_machine_multi #(
  parameter int NUM_ITEMS  = 8,
  parameter int CREDIT_W   = 8,
  parameter int STOCK_W    = 4,
  parameter int INIT_STOCK = 5,
  parameter int IDX_W      = $clog2(NUM_ITEMS)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          coin_valid,
  input  logic [CREDIT_W-1:0]           coin_value,
  input  logic                          sel_valid,
  input  logic [IDX_W-1:0]              sel_idx,
  input  logic                          cancel,
  input  logic [NUM_ITEMS*CREDIT_W-1:0] price_table,
  input  logic                          restock_valid,
  input  logic [IDX_W-1:0]              restock_idx,
  input  logic [STOCK_W-1:0]            restock_count,
  input  logic                          change_ready,
  output logic                          dispense,
  output logic [IDX_W-1:0]              dispense_idx,
  output logic                          change_valid,
  output logic [CREDIT_W-1:0]           change_amount,
  output logic [CREDIT_W-1:0]           credit,
  output logic                          coin_reject,
  output logic                          sel_error,
  output logic                          busy
);
  localparam int SLOTS = 1 << IDX_W;
  typedef enum logic [1:0] {IDLE, COLLECT, DISPENSE, CHANGE} state_t;
  state_t state;
  logic [CREDIT_W-1:0] price [SLOTS];
  logic [STOCK_W-1:0]  stock [SLOTS];
  logic [SLOTS-1:0]    present;
  logic [CREDIT_W:0]   coin_sum;
  logic [STOCK_W:0]    restock_sum;
  logic [STOCK_W-1:0]  restock_new;
  logic [CREDIT_W-1:0] remain;
  logic                coin_ovf, sel_bad, restock_ok;
  // index space is padded to a power of two; slots past NUM_ITEMS never exist
  for (genvar g = 0; g < SLOTS; g++) begin : slot
    if (g < NUM_ITEMS) begin : real_item
      assign price[g]   = price_table[g*CREDIT_W +: CREDIT_W];
      assign present[g] = 1'b1;
    end else begin : pad
      assign price[g]   = '0;
      assign present[g] = 1'b0;
    end
  end
  always_comb begin
    coin_sum    = {1'b0, credit} + {1'b0, coin_value};
    coin_ovf    = coin_sum[CREDIT_W];
    sel_bad     = !present[sel_idx] || stock[sel_idx] == '0 || credit < price[sel_idx];
    remain      = credit - price[dispense_idx];
    restock_sum = {1'b0, stock[restock_idx]} + {1'b0, restock_count};
    restock_new = restock_sum[STOCK_W] ? '1 : restock_sum[STOCK_W-1:0];
    restock_ok  = restock_valid && present[restock_idx] && (state == IDLE || state == COLLECT);
  end
  // restock is blocked in DISPENSE, so it never collides with the decrement
  always_ff @(posedge clk or posedge rst)
    if (rst)
      for (int i = 0; i < SLOTS; i++)
        stock[i] <= i < NUM_ITEMS ? STOCK_W'(INIT_STOCK) : '0;
    else
      for (int i = 0; i < SLOTS; i++)
        if (state == DISPENSE && dispense_idx == IDX_W'(i))
          stock[i] <= stock[i] - STOCK_W'(1);
        else if (restock_ok && restock_idx == IDX_W'(i))
          stock[i] <= restock_new;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state         <= IDLE;
      credit        <= '0;
      dispense      <= 1'b0;
      dispense_idx  <= '0;
      change_valid  <= 1'b0;
      change_amount <= '0;
      coin_reject   <= 1'b0;
      sel_error     <= 1'b0;
      busy          <= 1'b0;
    end else begin
      dispense    <= 1'b0;
      coin_reject <= 1'b0;
      sel_error   <= 1'b0;
      case (state)
        IDLE: begin
          sel_error   <= sel_valid;
          coin_reject <= coin_valid && coin_ovf;
          if (coin_valid && !coin_ovf && coin_value != '0) begin
            credit <= coin_sum[CREDIT_W-1:0];
            state  <= COLLECT;
          end
        end
        COLLECT:
          if (cancel) begin
            coin_reject   <= coin_valid;
            change_valid  <= 1'b1;
            change_amount <= credit;
            busy          <= 1'b1;
            state         <= CHANGE;
          end else if (sel_valid) begin
            coin_reject <= coin_valid;
            sel_error   <= sel_bad;
            if (!sel_bad) begin
              dispense     <= 1'b1;
              dispense_idx <= sel_idx;
              busy         <= 1'b1;
              state        <= DISPENSE;
            end
          end else if (coin_valid) begin
            coin_reject <= coin_ovf;
            if (!coin_ovf) credit <= coin_sum[CREDIT_W-1:0];
          end
        DISPENSE: begin
          coin_reject   <= coin_valid;
          credit        <= remain;
          change_valid  <= remain != '0;
          change_amount <= remain;
          busy          <= remain != '0;
          state         <= remain != '0 ? CHANGE : IDLE;
        end
        CHANGE: begin
          coin_reject <= coin_valid;
          if (change_valid && change_ready) begin
            credit        <= '0;
            change_valid  <= 1'b0;
            change_amount <= '0;
            busy          <= 1'b0;
            state         <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_vending_machine_multi.sv
// tb_vending_machine_multi: directed self-checking bench for vending_machine_multi
module tb_vending_machine_multi;
  localparam int N = 6, CW = 8, SW = 4, IW = 3;
  logic clk = 1'b0, rst = 1'b1;
  logic coin_valid = 1'b0, sel_valid = 1'b0, cancel = 1'b0, restock_valid = 1'b0, change_ready = 1'b0;
  logic [CW-1:0] coin_value = '0;
  logic [IW-1:0] sel_idx = '0, restock_idx = '0;
  logic [SW-1:0] restock_count = '0;
  logic [N*CW-1:0] price_table = {8'd15, 8'd0, 8'd50, 8'd30, 8'd10, 8'd25};
  logic dispense, change_valid, coin_reject, sel_error, busy;
  logic [IW-1:0] dispense_idx;
  logic [CW-1:0] change_amount, credit;
  int checks = 0, passes = 0;
  always #5 clk = ~clk;
  vending_machine_multi #(.NUM_ITEMS(N), .CREDIT_W(CW), .STOCK_W(SW), .INIT_STOCK(5)) dut (
    .clk(clk), .rst(rst), .coin_valid(coin_valid), .coin_value(coin_value),
    .sel_valid(sel_valid), .sel_idx(sel_idx), .cancel(cancel), .price_table(price_table),
    .restock_valid(restock_valid), .restock_idx(restock_idx), .restock_count(restock_count),
    .change_ready(change_ready), .dispense(dispense), .dispense_idx(dispense_idx),
    .change_valid(change_valid), .change_amount(change_amount), .credit(credit),
    .coin_reject(coin_reject), .sel_error(sel_error), .busy(busy));
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got === exp) passes++;
    else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic coin(input logic [CW-1:0] v);
    coin_valid = 1'b1;
    coin_value = v;
    tick();
    coin_valid = 1'b0;
    coin_value = '0;
  endtask
  task automatic sel(input logic [IW-1:0] i);
    sel_valid = 1'b1;
    sel_idx = i;
    tick();
    sel_valid = 1'b0;
  endtask
  task automatic refund();
    cancel = 1'b1;
    tick();
    cancel = 1'b0;
    change_ready = 1'b1;
    tick();
    change_ready = 1'b0;
    check("refund_done", 32'(change_valid), 0);
  endtask
  initial begin
    tick();
    tick();
    check("rst_credit", 32'(credit), 0);
    check("rst_outs", 32'({dispense, dispense_idx, change_valid, change_amount, coin_reject, sel_error, busy}), 0);
    rst = 1'b0;
    coin(0);
    check("zero_coin_credit", 32'(credit), 0);
    check("zero_coin_rej", 32'(coin_reject), 0);
    sel(2);
    check("idle_sel_err", 32'(sel_error), 1);
    // purchase with change
    coin(20);
    check("credit_20", 32'(credit), 20);
    coin(20);
    check("credit_40", 32'(credit), 40);
    sel(2);
    check("disp_pulse", 32'(dispense), 1);
    check("disp_idx", 32'(dispense_idx), 2);
    check("disp_busy", 32'(busy), 1);
    tick();
    check("disp_end", 32'(dispense), 0);
    check("chg_valid", 32'(change_valid), 1);
    check("chg_amt", 32'(change_amount), 10);
    check("chg_credit", 32'(credit), 10);
    change_ready = 1'b1;
    tick();
    change_ready = 1'b0;
    check("hs_credit", 32'(credit), 0);
    check("hs_valid", 32'(change_valid), 0);
    check("hs_busy", 32'(busy), 0);
    // exact payment until sold out
    for (int k = 0; k < 5; k++) begin
      coin(25);
      sel(0);
      check("exact_disp", 32'(dispense), 1);
      tick();
      check("exact_credit", 32'(credit), 0);
      check("exact_nochg", 32'(change_valid), 0);
      check("exact_idle", 32'(busy), 0);
    end
    coin(25);
    sel(0);
    check("soldout_err", 32'(sel_error), 1);
    check("soldout_nodisp", 32'(dispense), 0);
    check("soldout_credit", 32'(credit), 25);
    refund();
    // insufficient credit and invalid index
    coin(10);
    sel(3);
    check("short_err", 32'(sel_error), 1);
    check("short_credit", 32'(credit), 10);
    sel(7);
    check("badidx_err", 32'(sel_error), 1);
    cancel = 1'b1;
    tick();
    cancel = 1'b0;
    check("cancel_valid", 32'(change_valid), 1);
    check("cancel_amt", 32'(change_amount), 10);
    change_ready = 1'b1;
    tick();
    change_ready = 1'b0;
    // credit saturation and coins during CHANGE
    coin(200);
    coin(50);
    check("credit_250", 32'(credit), 250);
    coin(10);
    check("sat_rej", 32'(coin_reject), 1);
    check("sat_credit", 32'(credit), 250);
    cancel = 1'b1;
    tick();
    cancel = 1'b0;
    for (int k = 0; k < 4; k++) begin
      coin(5);
      check("chg_coin_rej", 32'(coin_reject), 1);
      check("chg_amt_stable", 32'(change_amount), 250);
      check("chg_still_valid", 32'(change_valid), 1);
    end
    change_ready = 1'b1;
    tick();
    change_ready = 1'b0;
    check("sat_drained", 32'(credit), 0);
    // cancel + sel + coin together
    coin(30);
    cancel = 1'b1;
    sel_valid = 1'b1;
    sel_idx = 2;
    coin_valid = 1'b1;
    coin_value = 10;
    tick();
    {cancel, sel_valid, coin_valid} = '0;
    check("sim_chg", 32'(change_valid), 1);
    check("sim_amt", 32'(change_amount), 30);
    check("sim_rej", 32'(coin_reject), 1);
    check("sim_nodisp", 32'(dispense), 0);
    check("sim_noerr", 32'(sel_error), 0);
    change_ready = 1'b1;
    tick();
    change_ready = 1'b0;
    // price-zero item keeps credit, returned as change
    coin(5);
    sel(4);
    check("free_disp", 32'(dispense), 1);
    check("free_idx", 32'(dispense_idx), 4);
    tick();
    check("free_chg", 32'(change_amount), 5);
    change_ready = 1'b1;
    tick();
    change_ready = 1'b0;
    // restock saturation: item 1 at stock 4, +15 -> 15 units
    coin(10);
    sel(1);
    tick();
    restock_valid = 1'b1;
    restock_idx = 1;
    restock_count = 15;
    tick();
    restock_valid = 1'b0;
    for (int k = 0; k < 15; k++) begin
      coin(10);
      sel(1);
      check("restock_disp", 32'(dispense), 1);
      tick();
    end
    coin(10);
    sel(1);
    check("restock_empty", 32'(sel_error), 1);
    refund();
    // async reset in CHANGE
    coin(20);
    cancel = 1'b1;
    tick();
    cancel = 1'b0;
    check("pre_rst_chg", 32'(change_valid), 1);
    #2 rst = 1'b1;
    #1;
    check("arst_chg", 32'(change_valid), 0);
    check("arst_credit", 32'(credit), 0);
    check("arst_busy", 32'(busy), 0);
    tick();
    rst = 1'b0;
    coin(25);
    sel(0);
    check("arst_stock", 32'(dispense), 1);
    tick();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
